// File: rtl/subtractor.sv
// Bit-level full subtractor with a registered single-bit path and an LSB-first
// serial word subtractor that chains the borrow between consecutive valid bits.
module subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    input  logic             in_valid,
    input  logic             ser_mode,
    output logic             diff,
    output logic             borrow,
    output logic             diff_q,
    output logic             borrow_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] ser_result,
    output logic             ser_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [CW-1:0] bit_cnt;
    logic          ser_bor;
    logic          bin;
    logic          d_bit;
    logic          b_bit;
    logic          last_bit;

    // Raw full subtractor on the pins; never touched by clock, reset or mode.
    assign diff   = x ^ y ^ z;
    assign borrow = (~x & y) | (~x & z) | (y & z);

    // Bit 0 of a serial word (and every single-bit op) takes its borrow from z;
    // later serial bits take the borrow carried from the previous bit.
    assign bin      = (ser_mode && (bit_cnt != '0)) ? ser_bor : z;
    assign d_bit    = x ^ y ^ bin;
    assign b_bit    = (~x & y) | (~x & bin) | (y & bin);
    assign last_bit = (bit_cnt == LAST_BIT);

    // in_valid is a one-cycle qualifier with no backpressure: every cycle it is
    // high consumes one bit, and out_valid reports that bit's result one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q     <= 1'b0;
            borrow_q   <= 1'b0;
            out_valid  <= 1'b0;
            ser_done   <= 1'b0;
            ser_bor    <= 1'b0;
            bit_cnt    <= '0;
            ser_result <= '0;
        end else if (in_valid) begin
            diff_q    <= d_bit;
            borrow_q  <= b_bit;
            out_valid <= 1'b1;
            if (ser_mode) begin
                ser_result <= {d_bit, ser_result[WIDTH-1:1]};
                if (last_bit) begin
                    bit_cnt  <= '0;
                    ser_bor  <= 1'b0;
                    ser_done <= 1'b1;
                end else begin
                    bit_cnt  <= bit_cnt + 1'b1;
                    ser_bor  <= b_bit;
                    ser_done <= 1'b0;
                end
            end else begin
                // A single-bit op abandons any partial serial word.
                bit_cnt  <= '0;
                ser_bor  <= 1'b0;
                ser_done <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
            ser_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_subtractor.sv
// Randomised bench for subtractor: word-level arithmetic reference model,
// expected-result queue and a negedge monitor that checks every DUT output.
module tb_subtractor;

    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 3;

    logic             clk;
    logic             rst_n;
    logic             x;
    logic             y;
    logic             z;
    logic             in_valid;
    logic             ser_mode;
    logic             diff;
    logic             borrow;
    logic             diff_q;
    logic             borrow_q;
    logic             out_valid;
    logic [WIDTH-1:0] ser_result;
    logic             ser_done;

    int checks;
    int errors;

    // Expected entry layout: {ser_result, ser_done, borrow_q, diff_q}
    logic [EW-1:0] exp_q[$];

    // Reference model state: bits of the current serial word collected so far.
    int     m_cnt;
    longint m_a;
    longint m_b;
    longint m_z0;

    subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .z          (z),
        .in_valid   (in_valid),
        .ser_mode   (ser_mode),
        .diff       (diff),
        .borrow     (borrow),
        .diff_q     (diff_q),
        .borrow_q   (borrow_q),
        .out_valid  (out_valid),
        .ser_result (ser_result),
        .ser_done   (ser_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_comb();
        int r;
        r = int'(x) - int'(y) - int'(z);
        check("diff_comb", 32'(diff), 32'(r & 1));
        check("borrow_comb", 32'(borrow), 32'(r < 0));
    endtask

    // Monitor: combinational outputs every cycle, registered results whenever out_valid.
    logic [EW-1:0] mon_e;
    always @(negedge clk) begin
        check_comb();
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 expected=0 at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("diff_q", 32'(diff_q), 32'(mon_e[0]));
                    check("borrow_q", 32'(borrow_q), 32'(mon_e[1]));
                    check("ser_done", 32'(ser_done), 32'(mon_e[2]));
                    if (mon_e[2]) check("ser_result", 32'(ser_result), 32'(mon_e[EW-1:3]));
                end
            end else begin
                check("ser_done_idle", 32'(ser_done), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_clear();
        m_cnt = 0;
        m_a   = 0;
        m_b   = 0;
        m_z0  = 0;
    endtask

    // Called just after a rising edge; presents one valid bit for one cycle.
    task automatic issue(input logic xi, input logic yi, input logic zi, input logic mi);
        longint     t;
        logic       ed;
        logic       eb;
        logic       edone;
        logic [WIDTH-1:0] er;
        x        = xi;
        y        = yi;
        z        = zi;
        ser_mode = mi;
        in_valid = 1'b1;
        if (mi) begin
            if (m_cnt == 0) m_z0 = longint'(zi);
            m_a   = m_a | (longint'(xi) << m_cnt);
            m_b   = m_b | (longint'(yi) << m_cnt);
            t     = m_a - m_b - m_z0;
            ed    = t[m_cnt];
            eb    = (m_a < m_b + m_z0);
            edone = (m_cnt == WIDTH - 1);
            er    = t[WIDTH-1:0];
            if (edone) model_clear();
            else m_cnt++;
        end else begin
            t     = longint'(xi) - longint'(yi) - longint'(zi);
            ed    = t[0];
            eb    = (t < 0);
            edone = 1'b0;
            er    = '0;
            model_clear();
        end
        exp_q.push_back({er, edone, eb, ed});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            x        = 1'($urandom_range(0, 1));
            y        = 1'($urandom_range(0, 1));
            z        = 1'($urandom_range(0, 1));
            ser_mode = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // Serial word, LSB first; gap cycles are inserted after bit index gap_at (-1 = none).
    task automatic run_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic z0, input int gap_at, input int gap_len);
        for (int i = 0; i < WIDTH; i++) begin
            issue(a[i], b[i], (i == 0) ? z0 : 1'($urandom_range(0, 1)), 1'b1);
            if (i == gap_at) idle(gap_len);
        end
    endtask

    task automatic check_reset_state();
        check("rst_diff_q", 32'(diff_q), 32'd0);
        check("rst_borrow_q", 32'(borrow_q), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ser_done", 32'(ser_done), 32'd0);
        check("rst_ser_result", 32'(ser_result), 32'd0);
    endtask

    // Called just after a rising edge; the result of that edge is discarded.
    task automatic pulse_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] combo;
        int         r;
        checks = 0;
        errors = 0;
        model_clear();
        rst_n    = 1'b0;
        x        = 1'b0;
        y        = 1'b1;
        z        = 1'b0;
        in_valid = 1'b0;
        ser_mode = 1'b0;

        #4;
        check("no_clk_diff", 32'(diff), 32'd1);
        check("no_clk_borrow", 32'(borrow), 32'd1);
        check_reset_state();

        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            {x, y, z} = combo;
            #1;
            check_comb();
        end

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-bit registered mode, then strobe drops.
        issue(1'b1, 1'b1, 1'b1, 1'b0);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_diff_q", 32'(diff_q), 32'd1);
        check("single_borrow_q", 32'(borrow_q), 32'd1);
        idle(1);
        check("single_out_valid_drop", 32'(out_valid), 32'd0);

        // 0x05 - 0x0A then 0x0A - 0x05 back-to-back.
        run_word(8'h05, 8'h0A, 1'b0, -1, 0);
        check("word_fb_result", 32'(ser_result), 32'h0FB);
        check("word_fb_borrow", 32'(borrow_q), 32'd1);
        check("word_fb_done", 32'(ser_done), 32'd1);
        run_word(8'h0A, 8'h05, 1'b0, -1, 0);
        check("word_05_result", 32'(ser_result), 32'h005);
        check("word_05_borrow", 32'(borrow_q), 32'd0);
        idle(1);
        check("done_pulse_drop", 32'(ser_done), 32'd0);

        // Gap of three idle cycles between bits 3 and 4.
        run_word(8'h05, 8'h0A, 1'b0, 3, 3);
        check("gap_result", 32'(ser_result), 32'h0FB);
        idle(2);

        // Reset after three serial bits, then a clean word.
        for (int i = 0; i < 3; i++) issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        pulse_reset();
        run_word(8'h05, 8'h0A, 1'b0, -1, 0);
        check("post_reset_result", 32'(ser_result), 32'h0FB);

        // Random full words with random borrow-in and gaps.
        for (int w = 0; w < 20; w++) begin
            run_word(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, WIDTH)) - 1, int'($urandom_range(1, 3)));
        end

        // Random mix: serial bits, single-bit ops, gaps and occasional resets.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) pulse_reset();
            else if (r < 15) idle(int'($urandom_range(1, 3)));
            else issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0));
        end

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
